ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: stall  in  1  hold all registers; flush  in  1  load a bubble.
REQ-004 SHALL have: ex_valid  in  1; ex_pc  in  32; ex_alu_out  in  32; ex_zero  in  1; ex_overflow  in  1 (from ALU).
REQ-005 SHALL have: ex_ovf_check  in  1  instruction is trapping ADD/SUB; ex_rt_data  in  32  store data; ex_rd  in  5  destination register.
REQ-006 SHALL have: ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne  in  1 each; ex_branch_target  in  32.
REQ-007 SHALL have: exc_ack  in  1  handler accepted the exception.
REQ-008 SHALL have outputs: mem_valid 1; mem_alu_out 32; mem_rt_data 32; mem_rd 5; mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg 1 each.
REQ-009 SHALL have outputs: branch_taken 1; branch_target 32; exc_req 1; epc 32; exc_cause 5; ovf_count 16.

Function
REQ-010 SHALL be a one-cycle register stage: values accepted on edge N appear on outputs after edge N.
REQ-011 SHALL apply update priority per edge: rst > flush > stall > trap squash > normal load.
REQ-012 Normal load SHALL copy all ex_* fields to matching mem_* outputs; mem_valid = ex_valid.
REQ-013 Bubble (flush, squash, or ex_valid=0) SHALL set mem_valid and all mem_* control bits to 0; data fields to 0.
REQ-014 stall=1 SHALL hold every register, including FSM, epc and ovf_count; stall+flush SHALL flush.
REQ-015 branch_taken SHALL register ex_valid & ex_branch & (ex_zero XOR ex_branch_ne) on a normal load; 0 otherwise; branch_target registers ex_branch_target.
REQ-016 Trap condition SHALL be ex_valid & ex_overflow & ex_ovf_check with stall=0, flush=0, state IDLE.
REQ-017 On trap: load bubble (no register write, no memory access), epc <= ex_pc, exc_cause <= EXC_OV (5'd12), branch_taken <= 0, state -> TRAP.
REQ-018 FSM states SHALL be IDLE and TRAP; exc_req = 1 exactly while in TRAP.
REQ-019 In TRAP every incoming instruction SHALL be loaded as a bubble; further overflows SHALL NOT change epc or ovf_count.
REQ-020 exc_ack=1 in TRAP SHALL return state to IDLE on that edge; exc_ack in IDLE SHALL be ignored.
REQ-021 epc and exc_cause SHALL hold their values until the next trap.
REQ-022 ovf_count SHALL increment by 1 per trap, saturating at 16'hFFFF.
REQ-023 ex_overflow with ex_ovf_check=0 SHALL NOT trap; ex_alu_out SHALL pass through unchanged.

Reset
REQ-024 rst=1 SHALL immediately, without clock, force every output and register to 0 and state to IDLE.
REQ-025 rst asserted during TRAP SHALL drop exc_req at once; epc and ovf_count SHALL clear.

Structure
REQ-026 Package ex_mem_pkg SHALL hold the state encoding (IDLE=1'b0, TRAP=1'b1), EXC_OV, and the OVF_CNT_W=16 constant.
REQ-027 The block SHALL be a single module; no sub-module is required.

Verification
REQ-028 Load ex_valid=1, ex_alu_out=32'h0000_0010, ex_rd=5'd8, ex_reg_write=1 -> next cycle mem_alu_out=32'h10, mem_rd=8, mem_reg_write=1, mem_valid=1.
REQ-029 ex_branch=1, ex_zero=1, ex_branch_ne=0, target 32'h0040_0020 -> branch_taken=1, branch_target=32'h0040_0020; with ex_branch_ne=1 -> branch_taken=0.
REQ-030 ex_pc=32'h0040_0008, ex_overflow=1, ex_ovf_check=1, ex_reg_write=1 -> mem_reg_write=0, mem_valid=0, exc_req=1, epc=32'h0040_0008, exc_cause=12, ovf_count=1; exc_req holds until exc_ack, then 0.
REQ-031 stall=1 for 3 cycles with changing inputs -> outputs constant; stall=1 with flush=1 -> bubble.
REQ-032 Assert rst mid-cycle while exc_req=1 -> all outputs 0 before the next clock edge.
REQ-033 Force ovf_count to 16'hFFFE, run 3 traps with acks -> ovf_count ends at 16'hFFFF.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register stage.
package ex_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_t;

  localparam logic [4:0]  EXC_OV    = 5'd12;
  localparam int unsigned OVF_CNT_W = 16;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;

  // Everything that travels from EX into MEM as one registered payload
  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  alu_out;
    logic [XLEN-1:0]  rt_data;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
  } mem_payload_t;

endpackage

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall/flush control and an overflow trap FSM.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_out,
  input  logic        ex_zero,
  input  logic        ex_overflow,
  input  logic        ex_ovf_check,
  input  logic [31:0] ex_rt_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic        ex_branch,
  input  logic        ex_branch_ne,
  input  logic [31:0] ex_branch_target,
  input  logic        exc_ack,
  output logic        mem_valid,
  output logic [31:0] mem_alu_out,
  output logic [31:0] mem_rt_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        mem_mem_to_reg,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        exc_req,
  output logic [31:0] epc,
  output logic [4:0]  exc_cause,
  output logic [15:0] ovf_count
);

  state_t                 state_q, state_d;
  mem_payload_t           pl_q, pl_d;
  logic [XLEN-1:0]        epc_q;
  logic [4:0]             cause_q;
  logic [OVF_CNT_W-1:0]   ovf_cnt_q;
  logic                   trap_c;
  logic                   load_c;
  logic                   bubble_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Trap detection, next state and the payload selected for this edge
  always_comb begin
    state_d  = state_q;
    trap_c   = 1'b0;
    load_c   = flush | ~stall;
    bubble_c = 1'b0;
    pl_d     = '0;

    case (state_q)
      IDLE: begin
        trap_c = ~stall & ~flush & ex_valid & ex_overflow & ex_ovf_check;
        if (trap_c) state_d = TRAP;
      end
      TRAP: begin
        if (exc_ack && load_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bubble_c = flush | trap_c | (state_q == TRAP) | ~ex_valid;

    if (!bubble_c) begin
      pl_d.valid         = 1'b1;
      pl_d.alu_out       = ex_alu_out;
      pl_d.rt_data       = ex_rt_data;
      pl_d.rd            = ex_rd;
      pl_d.reg_write     = ex_reg_write;
      pl_d.mem_read      = ex_mem_read;
      pl_d.mem_write     = ex_mem_write;
      pl_d.mem_to_reg    = ex_mem_to_reg;
      pl_d.branch_taken  = ex_branch & (ex_zero ^ ex_branch_ne);
      pl_d.branch_target = ex_branch_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pl_q      <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      if (load_c) pl_q <= pl_d;
      if (trap_c) begin
        epc_q   <= ex_pc;
        cause_q <= EXC_OV;
        if (ovf_cnt_q != {OVF_CNT_W{1'b1}})
          ovf_cnt_q <= ovf_cnt_q + OVF_CNT_W'(1);
      end
    end
  end

  assign mem_valid      = pl_q.valid;
  assign mem_alu_out    = pl_q.alu_out;
  assign mem_rt_data    = pl_q.rt_data;
  assign mem_rd         = pl_q.rd;
  assign mem_reg_write  = pl_q.reg_write;
  assign mem_mem_read   = pl_q.mem_read;
  assign mem_mem_write  = pl_q.mem_write;
  assign mem_mem_to_reg = pl_q.mem_to_reg;
  assign branch_taken   = pl_q.branch_taken;
  assign branch_target  = pl_q.branch_target;
  assign exc_req        = (state_q == TRAP);
  assign epc            = epc_q;
  assign exc_cause      = cause_q;
  assign ovf_count      = ovf_cnt_q;

endmodule
